// File: rtl/mem_access_pkg.sv
// LC3 memory-access stage shared types.
// Operation and state encodings plus default bus widths.
package lc3_mem_pkg;

  localparam int LC3_AW = 16;
  localparam int LC3_DW = 16;

  typedef enum logic [1:0] {
    READ      = 2'd0,
    READ_IND  = 2'd1,
    WRITE     = 2'd2,
    WRITE_IND = 2'd3
  } mem_op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_PTR = 3'd1,
    RD     = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } mem_state_t;

  // Indirect ops (LDI/STI) are the odd encodings.
  function automatic logic is_ind(mem_op_t op);
    return op[0];
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// LC3 memory-access stage port bundle.
// Execute-side start, data-memory req/ack port and writeback result.
interface mem_access_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  logic          enable_mem;
  logic [1:0]    M_Control;
  logic [AW-1:0] M_addr;
  logic [DW-1:0] M_data;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic [DW-1:0] memout;
  logic          busy;
  logic          mem_done;

  modport slave (
    input  enable_mem, M_Control, M_addr, M_data,
    input  dmem_ack, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output memout, busy, mem_done
  );

  modport master (
    output enable_mem, M_Control, M_addr, M_data,
    output dmem_ack, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  memout, busy, mem_done
  );

endinterface

// File: rtl/mem_access.sv
// LC3 memory-access stage: one data-memory transaction per op.
// Indirect ops read the pointer first, then access through it.
module mem_access
  import lc3_mem_pkg::*;
#(
  parameter int AW = LC3_AW,
  parameter int DW = LC3_DW
) (
  input  logic   clk,
  input  logic   rst,
  mem_access_if.slave bus
);

  mem_state_t    state_q, state_d;
  mem_op_t       op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] memout_q, memout_d;
  logic [AW-1:0] tgt;

  // Next-state and datapath capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    memout_d = memout_q;
    unique case (state_q)
      IDLE: begin
        if (bus.enable_mem) begin
          op_d   = mem_op_t'(bus.M_Control);
          addr_d = bus.M_addr;
          data_d = bus.M_data;
          unique case (mem_op_t'(bus.M_Control))
            READ:    state_d = RD;
            WRITE:   state_d = WR;
            default: state_d = RD_PTR;
          endcase
        end
      end
      RD_PTR: begin
        if (bus.dmem_ack) begin
          // Pointer width follows address width.
          ptr_d   = AW'(bus.dmem_rdata);
          state_d = (op_q == READ_IND) ? RD : WR;
        end
      end
      RD: begin
        if (bus.dmem_ack) begin
          memout_d = bus.dmem_rdata;
          state_d  = DONE;
        end
      end
      WR: begin
        if (bus.dmem_ack) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= READ;
      addr_q   <= '0;
      data_q   <= '0;
      ptr_q    <= '0;
      memout_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ptr_q    <= ptr_d;
      memout_q <= memout_d;
    end
  end

  assign tgt = is_ind(op_q) ? ptr_q : addr_q;

  // Moore output decode from state and registers only.
  always_comb begin
    bus.dmem_req   = 1'b0;
    bus.dmem_we    = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.mem_done   = 1'b0;
    unique case (state_q)
      RD_PTR: begin
        bus.dmem_req  = 1'b1;
        bus.dmem_addr = addr_q;
      end
      RD: begin
        bus.dmem_req  = 1'b1;
        bus.dmem_addr = tgt;
      end
      WR: begin
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = 1'b1;
        bus.dmem_addr  = tgt;
        bus.dmem_wdata = data_q;
      end
      DONE:    bus.mem_done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.memout = memout_q;

endmodule
